// File: rtl/gcm_ctr_sequencer.sv
// gcm_ctr_sequencer
// Front-end sequencer for the AES-GCM datapath. It pops a framed message
// from a first-word-fall-through rx FIFO (IV word, AAD byte length word,
// payload byte length word, AAD blocks, payload blocks) and fans it out:
//   - masked AAD blocks and the final length block on the GHASH channel,
//   - counter / masked payload / byte-mask triples on the cipher channel,
//   - the tag counter J0 = IV || 1.
// Ports:
//   i_clk, i_rst                : clock, synchronous active-high reset
//   i_rxEmpty, i_rxData, o_rxPop: rx FIFO head and consume strobe
//   o_ghData/o_ghValid/o_ghLast : GHASH channel, accepted on i_ghReady
//   o_ctrBlk/o_ptBlk/o_ptMask   : cipher channel, valid on o_ctrValid,
//                                 accepted on i_ctrReady
//   o_tagCtr                    : J0 of the current/last message
//   o_busy, o_finish            : message in progress, completion pulse
module gcm_ctr_sequencer #(
    parameter int LEN_W = 32,
    parameter int CTR_W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_rxEmpty,
    input  logic [127:0] i_rxData,
    output logic         o_rxPop,
    output logic [127:0] o_ghData,
    output logic         o_ghValid,
    output logic         o_ghLast,
    input  logic         i_ghReady,
    output logic [127:0] o_ctrBlk,
    output logic [127:0] o_ptBlk,
    output logic [127:0] o_ptMask,
    output logic         o_ctrValid,
    input  logic         i_ctrReady,
    output logic [127:0] o_tagCtr,
    output logic         o_busy,
    output logic         o_finish
);

    localparam int IV_W = 128 - CTR_W;
    // Block counts need one bit more than a 36-bit length so ceil() cannot overflow.
    localparam int BW   = 37;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_IV, S_HDR_A, S_HDR_P, S_AAD, S_DATA, S_LEN, S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IV_W-1:0] r_iv;
    logic [CTR_W-1:0] r_ctr;
    logic [35:0]     r_alen;
    logic [35:0]     r_plen;
    logic [BW-1:0]   r_aBlk;
    logic [BW-1:0]   r_pBlk;
    logic [127:0]    r_ghData;
    logic            r_ghValid;
    logic            r_ghLast;
    logic [127:0]    r_ctrBlk;
    logic [127:0]    r_ptBlk;
    logic [127:0]    r_ptMask;
    logic            r_ctrValid;
    logic [127:0]    r_tagCtr;
    logic            r_busy;
    logic            r_finish;

    logic            w_pop;
    logic            w_ghLoad;
    logic            w_ctrLoad;
    logic            w_done;
    logic            w_ghFree;
    logic            w_ctrFree;
    logic [35:0]     w_inLen;
    logic [BW-1:0]   w_inBlk;
    logic [127:0]    w_aMask;
    logic [127:0]    w_pMask;

    // Byte mask for the final block: r = len mod 16 leading bytes kept,
    // r = 0 means the final block is full.
    function automatic logic [127:0] tailMask(input logic [3:0] r);
        if (r == 4'd0)
            return '1;
        else
            return ~({128{1'b1}} >> {r, 3'b000});
    endfunction

    assign w_inLen   = 36'(i_rxData[LEN_W-1:0]);
    assign w_inBlk   = (BW'(w_inLen) + BW'(15)) >> 4;
    // A slot may be reloaded if it is empty or is being drained this cycle.
    assign w_ghFree  = !r_ghValid || i_ghReady;
    assign w_ctrFree = !r_ctrValid || i_ctrReady;
    assign w_aMask   = (r_aBlk == BW'(1)) ? tailMask(r_alen[3:0]) : '1;
    assign w_pMask   = (r_pBlk == BW'(1)) ? tailMask(r_plen[3:0]) : '1;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_ghLoad  = 1'b0;
        w_ctrLoad = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!i_rxEmpty)
                    w_next = S_HDR_IV;
            end
            S_HDR_IV: begin
                if (!i_rxEmpty) begin
                    w_pop  = 1'b1;
                    w_next = S_HDR_A;
                end
            end
            S_HDR_A: begin
                if (!i_rxEmpty) begin
                    w_pop  = 1'b1;
                    w_next = S_HDR_P;
                end
            end
            S_HDR_P: begin
                if (!i_rxEmpty) begin
                    w_pop = 1'b1;
                    if (r_aBlk != '0)
                        w_next = S_AAD;
                    else if (w_inBlk != '0)
                        w_next = S_DATA;
                    else
                        w_next = S_LEN;
                end
            end
            S_AAD: begin
                if (!i_rxEmpty && w_ghFree) begin
                    w_pop    = 1'b1;
                    w_ghLoad = 1'b1;
                    if (r_aBlk == BW'(1))
                        w_next = (r_pBlk != '0) ? S_DATA : S_LEN;
                end
            end
            S_DATA: begin
                if (!i_rxEmpty && w_ctrFree) begin
                    w_pop     = 1'b1;
                    w_ctrLoad = 1'b1;
                    if (r_pBlk == BW'(1))
                        w_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_ghFree) begin
                    w_ghLoad = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                // Both channels drained: the length block and last payload are gone.
                if (!r_ghValid && !r_ctrValid) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Header capture, block bookkeeping and the two output slots.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_iv       <= '0;
            r_ctr      <= '0;
            r_alen     <= '0;
            r_plen     <= '0;
            r_aBlk     <= '0;
            r_pBlk     <= '0;
            r_ghData   <= '0;
            r_ghValid  <= 1'b0;
            r_ghLast   <= 1'b0;
            r_ctrBlk   <= '0;
            r_ptBlk    <= '0;
            r_ptMask   <= '0;
            r_ctrValid <= 1'b0;
            r_tagCtr   <= '0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
        end else begin
            if (r_state == S_HDR_IV && w_pop) begin
                r_iv     <= i_rxData[127:CTR_W];
                r_tagCtr <= {i_rxData[127:CTR_W], CTR_W'(1)};
                r_ctr    <= CTR_W'(2);
            end
            if (r_state == S_HDR_A && w_pop) begin
                r_alen <= w_inLen;
                r_aBlk <= w_inBlk;
            end
            if (r_state == S_HDR_P && w_pop) begin
                r_plen <= w_inLen;
                r_pBlk <= w_inBlk;
            end

            if (w_ghLoad) begin
                r_ghValid <= 1'b1;
                if (r_state == S_LEN) begin
                    r_ghData <= {64'({r_alen, 3'b000}), 64'({r_plen, 3'b000})};
                    r_ghLast <= 1'b1;
                end else begin
                    r_ghData <= i_rxData & w_aMask;
                    r_ghLast <= 1'b0;
                    r_aBlk   <= r_aBlk - BW'(1);
                end
            end else if (i_ghReady) begin
                r_ghValid <= 1'b0;
            end

            if (w_ctrLoad) begin
                r_ctrValid <= 1'b1;
                r_ctrBlk   <= {r_iv, r_ctr};
                r_ptBlk    <= i_rxData & w_pMask;
                r_ptMask   <= w_pMask;
                r_ctr      <= r_ctr + CTR_W'(1);
                r_pBlk     <= r_pBlk - BW'(1);
            end else if (i_ctrReady) begin
                r_ctrValid <= 1'b0;
            end

            if (r_state == S_IDLE && w_next == S_HDR_IV)
                r_busy <= 1'b1;
            else if (w_done)
                r_busy <= 1'b0;
            r_finish <= w_done;
        end
    end

    assign o_rxPop    = w_pop;
    assign o_ghData   = r_ghData;
    assign o_ghValid  = r_ghValid;
    assign o_ghLast   = r_ghLast;
    assign o_ctrBlk   = r_ctrBlk;
    assign o_ptBlk    = r_ptBlk;
    assign o_ptMask   = r_ptMask;
    assign o_ctrValid = r_ctrValid;
    assign o_tagCtr   = r_tagCtr;
    assign o_busy     = r_busy;
    assign o_finish   = r_finish;

endmodule
